// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: grants one producer and one consumer per cycle into a shared FIFO and tracks
// its occupancy. Define FIFO_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module fifo_rr_arbiter #(
    parameter int unsigned Depth = 4,
    parameter int unsigned N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           push_req,
    input  logic [N_REQ-1:0]           pop_req,
    output logic [N_REQ-1:0]           push_gnt,
    output logic [N_REQ-1:0]           pop_gnt,
    output logic                       fifo_push,
    output logic                       fifo_pop,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] push_win, pop_win;
    logic            push_fire, pop_fire;

`ifdef FIFO_ARB_RR_EN
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N_REQ - 1);

    logic [IdxW-1:0] push_last_q, pop_last_q;

    // Search starts one past the last winner and wraps; first requester found wins.
    function automatic logic [IdxW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IdxW-1:0]  last);
        logic [IdxW-1:0] win;
        logic            found;
        int unsigned     idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last) + k) % N_REQ;
            if (!found && req[IdxW'(idx)]) begin
                win   = IdxW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_last_q <= IdxLast;
            pop_last_q  <= IdxLast;
        end else begin
            if (push_fire) push_last_q <= push_win;
            if (pop_fire)  pop_last_q  <= pop_win;
        end
    end

    assign push_win = rr_pick(push_req, push_last_q);
    assign pop_win  = rr_pick(pop_req, pop_last_q);
`else
    function automatic logic [IdxW-1:0] fp_pick(input logic [N_REQ-1:0] req);
        logic [IdxW-1:0] win;
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[IdxW'(i)]) win = IdxW'(i);
        end
        return win;
    endfunction

    assign push_win = fp_pick(push_req);
    assign pop_win  = fp_pick(pop_req);
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == CntFull);

    // Eligibility looks only at registered occupancy, so there is no same-cycle bypass.
    assign push_fire = reset && (|push_req) && !full;
    assign pop_fire  = reset && (|pop_req) && !empty;

    always_comb begin
        push_gnt = '0;
        pop_gnt  = '0;
        if (push_fire) push_gnt[push_win] = 1'b1;
        if (pop_fire)  pop_gnt[pop_win]   = 1'b1;
    end

    assign fifo_push = push_fire;
    assign fifo_pop  = pop_fire;

    always_comb begin
        count_d = count_q;
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifndef SYNTHESIS
    a_push_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(push_gnt));
    a_pop_onehot  : assert property (@(posedge clk) disable iff (!reset) $onehot0(pop_gnt));
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset) !(full && fifo_push));
    a_no_underrun : assert property (@(posedge clk) disable iff (!reset) !(empty && fifo_pop));
    a_count_range : assert property (@(posedge clk) disable iff (!reset) count_q <= CntFull);
`endif

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Shares one FIFO among N_REQ producers and N_REQ consumers. Each cycle it grants at most one push requester and at most one pop requester, using independent round-robin pointers. It drives the FIFO's push/pop strobes and tracks occupancy so that a full FIFO is never pushed and an empty FIFO is never popped. It sits between the requester ports and the FIFO pointer control, which consumes `fifo_push`/`fifo_pop` directly.

## Interface
- `Depth`, 4: FIFO entries; ≥2.
- `N_REQ`, 4: requesters per side; ≥2.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; low clears all state immediately.
- `push_req` input N_REQ: bit i high = producer i requests a write.
- `pop_req` input N_REQ: bit i high = consumer i requests a read.
- `push_gnt` output N_REQ: one-hot or zero; bit i = producer i's write occurs at this clock edge.
- `pop_gnt` output N_REQ: one-hot or zero; bit i = consumer i's read occurs at this clock edge.
- `fifo_push` output 1: OR of `push_gnt`.
- `fifo_pop` output 1: OR of `pop_gnt`.
- `count` output $clog2(Depth+1): current occupancy, 0..Depth.
- `empty` output 1: `count`==0.
- `full` output 1: `count`==Depth.

## Operation
- Occupancy state: EMPTY (`count`=0), PARTIAL (0<`count`<Depth), FULL (`count`=Depth). State is encoded by the `count` register.
- Push eligibility: some `push_req` bit set and state ≠ FULL.
- Pop eligibility: some `pop_req` bit set and state ≠ EMPTY.
- Eligibility uses only the registered `count`. There is no bypass:
  - EMPTY with push and pop requested: push granted, pop not.
  - FULL with push and pop requested: pop granted, push not.
- Winner selection (round-robin): registered `push_last`/`pop_last` pointers hold the index of the last winner on each side. The search starts at last+1 and wraps modulo N_REQ. The first requesting index wins.
- Pointer update: on a granted cycle, that side's pointer takes the winner's index. With no grant, it holds.
- Count update at the edge:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- Transitions: EMPTY→PARTIAL on push. PARTIAL→FULL on push-only at Depth−1. FULL→PARTIAL on pop. PARTIAL→EMPTY on pop-only at 1.
- Requester handshake:
  - A requester keeps its req high until it sees its gnt bit high in the same cycle.
  - A req held high after the grant edge is a new request.
  - Dropping req before a grant withdraws the request with no side effect.
- Reset (`reset` low, any time, including mid-transfer):
  - `count`=0, `empty`=1, `full`=0.
  - `push_last`=`pop_last`=N_REQ−1, so index 0 has first priority.
  - All gnt outputs and `fifo_push`/`fifo_pop` forced 0 while reset is low.

## Timing
- Grants are combinational from the current `push_req`/`pop_req` plus registered state. A request and its grant occur in the same cycle, with zero-cycle latency.
- The transfer completes at the rising edge that ends the grant cycle. `count`, `full` and `empty` reflect it one cycle after the grant.
- Sustained throughput: one push and one pop per cycle.
- After reset deasserts, grants are possible in the first cycle.

## Configuration
- `FIFO_ARB_RR_EN` defined: round-robin as described above.
- `FIFO_ARB_RR_EN` undefined: fixed priority, lowest requesting index wins. `push_last`/`pop_last` are not implemented. All other behaviour is unchanged.

## Test plan
- Reset and idle: hold `reset` low, then release with no requests. Expect `count`=0, `empty`=1, `full`=0 and all grants 0 throughout.
- Fill to full: `push_req`=4'b0001 held for 5 cycles, `Depth`=4. Expect `push_gnt`=0001 for 4 cycles, then 0. `count` steps 1,2,3,4 and `full`=1 after the 4th edge.
- Round-robin: `push_req`=4'b1111 held while FIFO drains each cycle. Expect grant order 0,1,2,3,0. With `FIFO_ARB_RR_EN` undefined, expect 0 every cycle.
- Boundaries:
  - At `count`=0, `push_req`=0001 and `pop_req`=0010: push granted, pop not, `count`→1.
  - At `count`=4, same stimulus: pop granted only, `count`→3.
- Simultaneous transfer: at `count`=2, push and pop requested every cycle for 10 cycles. Expect both granted every cycle and `count` stays 2.
- Reset mid-operation: assert `reset` low mid-cycle at `count`=3 with active requests. Expect grants drop immediately, `count`=0, and priority restarts at index 0.
